// File: rtl/rv32_mem.sv
// rv32_mem: RV32 memory stage.
// - Issues load/store requests on the data bus.
// - Performs byte/half lane steering and load extension.
// - Resolves branches combinationally.
// - Registers the writeback result.
// Optional feature: define RV32_MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning them.
module rv32_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [1:0]  branch_op_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_writeback_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] branch_pc_in,
  output logic [31:0] data_address_out,
  output logic        data_read_out,
  output logic        data_write_out,
  output logic [3:0]  data_write_mask_out,
  output logic [31:0] data_write_value_out,
  input  logic [31:0] data_read_value_in,
  input  logic        data_ready_in,
  output logic        busy_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_pc_out,
  output logic [4:0]  rd_out,
  output logic        rd_writeback_out,
  output logic [31:0] rd_value_out
`ifdef RV32_MEM_MISALIGN_TRAP_EN
  ,
  output logic        trap_out
`endif
);

  localparam logic [1:0] BR_NEVER    = 2'b00;
  localparam logic [1:0] BR_ZERO     = 2'b01;
  localparam logic [1:0] BR_NON_ZERO = 2'b10;
  localparam logic [1:0] BR_ALWAYS   = 2'b11;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // Byte-enable pattern for a store of the given width at the given low address bits.
  function automatic logic [3:0] store_mask(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so that the mask alone selects the bytes.
  function automatic logic [31:0] store_data(input logic [1:0] width, input logic [31:0] v);
    case (width)
      2'b00:   return {4{v[7:0]}};
      2'b01:   return {2{v[15:0]}};
      default: return v;
    endcase
  endfunction

  // Pick the addressed lane out of the bus word and extend it to 32 bits.
  function automatic logic [31:0] load_data(input logic [1:0] width, input logic zext,
                                            input logic [1:0] lo, input logic [31:0] v);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'b00:   b = v[7:0];
      2'b01:   b = v[15:8];
      2'b10:   b = v[23:16];
      default: b = v[31:24];
    endcase
    h = lo[1] ? v[31:16] : v[15:0];
    case (width)
      2'b00:   return {{24{~zext & b[7]}}, b};
      2'b01:   return {{16{~zext & h[15]}}, h};
      default: return v;
    endcase
  endfunction

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  // Half needs bit 0 clear, word (and the 11 encoding) needs both low bits clear.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction
`endif

  state_t      state_r;
  logic [31:0] addr_r;
  logic [1:0]  width_r;
  logic        zext_r;
  logic        read_r;
  logic        write_r;
  logic [3:0]  mask_r;
  logic [31:0] wdata_r;
  logic [4:0]  rd_r;
  logic        wb_r;
  // Result of a transfer that finished while the pipeline was stalled.
  logic        done_r;
  logic [4:0]  done_rd_r;
  logic        done_wb_r;
  logic [31:0] done_value_r;

  logic        mem_op_s;
  logic        misalign_s;
  logic        idle_access_s;
  logic        access_s;
  logic        complete_s;
  logic        busy_s;
  logic [31:0] req_addr_s;
  logic [31:0] req_wdata_s;
  logic [3:0]  req_mask_s;
  logic [1:0]  req_width_s;
  logic        req_zext_s;
  logic        req_read_s;
  logic        req_write_s;
  logic [31:0] load_value_s;
  logic [31:0] comp_value_s;
  logic [4:0]  comp_rd_s;
  logic        comp_wb_s;

  // A fresh access is only started from IDLE, unflushed, and not already done under stall.
  always_comb begin
    mem_op_s = (state_r == S_IDLE) & (mem_read_in | mem_write_in) & ~flush_in & ~done_r;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    misalign_s = mem_op_s & misaligned(mem_width_in, result_in[1:0]);
`else
    misalign_s = 1'b0;
`endif
    idle_access_s = mem_op_s & ~misalign_s;
  end

  // Active request: the latched copy while waiting, live inputs otherwise.
  always_comb begin
    req_addr_s  = result_in;
    req_width_s = mem_width_in;
    req_zext_s  = mem_zero_extend_in;
    req_read_s  = 1'b0;
    req_write_s = 1'b0;
    req_mask_s  = 4'b0000;
    req_wdata_s = 32'd0;
    access_s    = 1'b0;
    comp_rd_s   = rd_in;
    comp_wb_s   = rd_writeback_in;
    if (state_r == S_WAIT) begin
      req_addr_s  = addr_r;
      req_width_s = width_r;
      req_zext_s  = zext_r;
      req_read_s  = read_r;
      req_write_s = write_r;
      req_mask_s  = mask_r;
      req_wdata_s = wdata_r;
      access_s    = 1'b1;
      comp_rd_s   = rd_r;
      comp_wb_s   = wb_r & ~flush_in;
    end else begin
      req_read_s  = mem_read_in & idle_access_s;
      req_write_s = mem_write_in & idle_access_s;
      req_mask_s  = store_mask(mem_width_in, result_in[1:0]);
      req_wdata_s = store_data(mem_width_in, rs2_value_in);
      access_s    = idle_access_s;
    end
    complete_s   = access_s & data_ready_in;
    busy_s       = access_s & ~data_ready_in;
    load_value_s = load_data(req_width_s, req_zext_s, req_addr_s[1:0], data_read_value_in);
    comp_value_s = req_read_s ? load_value_s : req_addr_s;
  end

  // Bus request outputs, forced quiet while reset is asserted.
  always_comb begin
    data_address_out     = 32'd0;
    data_read_out        = 1'b0;
    data_write_out       = 1'b0;
    data_write_mask_out  = 4'b0000;
    data_write_value_out = 32'd0;
    busy_out             = 1'b0;
    if (rst_n) begin
      data_address_out = {req_addr_s[31:2], 2'b00};
      data_read_out    = req_read_s;
      data_write_out   = req_write_s;
      busy_out         = busy_s;
      if (req_write_s) begin
        data_write_mask_out  = req_mask_s;
        data_write_value_out = req_wdata_s;
      end else begin
        data_write_mask_out  = 4'b0000;
        data_write_value_out = 32'd0;
      end
    end else begin
      busy_out = 1'b0;
    end
  end

  // Branch resolution is purely combinational; a flush cancels the redirect.
  always_comb begin
    branch_pc_out = branch_pc_in;
    case (branch_op_in)
      BR_NEVER:    branch_taken_out = 1'b0;
      BR_ZERO:     branch_taken_out = ~flush_in & (result_in == 32'd0);
      BR_NON_ZERO: branch_taken_out = ~flush_in & (result_in != 32'd0);
      BR_ALWAYS:   branch_taken_out = ~flush_in;
      default:     branch_taken_out = 1'b0;
    endcase
  end

  // Bus FSM: latch the request when the bus is not ready on the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      addr_r  <= 32'd0;
      width_r <= 2'b00;
      zext_r  <= 1'b0;
      read_r  <= 1'b0;
      write_r <= 1'b0;
      mask_r  <= 4'b0000;
      wdata_r <= 32'd0;
      rd_r    <= 5'd0;
      wb_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (idle_access_s && !data_ready_in) begin
            state_r <= S_WAIT;
            addr_r  <= result_in;
            width_r <= mem_width_in;
            zext_r  <= mem_zero_extend_in;
            read_r  <= mem_read_in;
            write_r <= mem_write_in;
            mask_r  <= req_mask_s;
            wdata_r <= req_wdata_s;
            rd_r    <= rd_in;
            wb_r    <= rd_writeback_in;
          end
        end
        S_WAIT: begin
          // The transfer is never aborted; a flush only drops its writeback.
          if (data_ready_in) state_r <= S_IDLE;
          if (flush_in)      wb_r    <= 1'b0;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Park a result that completed under stall so the bus is not hit a second time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r       <= 1'b0;
      done_rd_r    <= 5'd0;
      done_wb_r    <= 1'b0;
      done_value_r <= 32'd0;
    end else if (!stall_in) begin
      done_r <= 1'b0;
    end else if (complete_s) begin
      done_r       <= 1'b1;
      done_rd_r    <= comp_rd_s;
      done_wb_r    <= comp_wb_s;
      done_value_r <= comp_value_s;
    end else if (done_r && flush_in) begin
      done_wb_r <= 1'b0;
    end
  end

  // Writeback registers advance only when the pipeline is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_out           <= 5'd0;
      rd_writeback_out <= 1'b0;
      rd_value_out     <= 32'd0;
    end else if (stall_in) begin
      rd_out           <= rd_out;
      rd_writeback_out <= rd_writeback_out;
      rd_value_out     <= rd_value_out;
    end else if (state_r == S_IDLE && done_r) begin
      rd_out           <= done_rd_r;
      rd_writeback_out <= done_wb_r & ~flush_in;
      rd_value_out     <= done_value_r;
    end else if (complete_s) begin
      rd_out           <= comp_rd_s;
      rd_writeback_out <= comp_wb_s;
      rd_value_out     <= comp_value_s;
    end else if (busy_s || (state_r == S_IDLE && (flush_in || misalign_s))) begin
      rd_out           <= 5'd0;
      rd_writeback_out <= 1'b0;
      rd_value_out     <= 32'd0;
    end else begin
      rd_out           <= rd_in;
      rd_writeback_out <= rd_writeback_in;
      rd_value_out     <= result_in;
    end
  end

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  // One-cycle trap pulse for a misaligned access that was suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_out <= 1'b0;
    end else begin
      trap_out <= ~stall_in & misalign_s;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_mem.sv
// Self-checking bench for rv32_mem: vector table plus hand-written multi-cycle sequences.
module tb_rv32_mem;

  localparam logic [1:0] BR_NEVER    = 2'b00;
  localparam logic [1:0] BR_ZERO     = 2'b01;
  localparam logic [1:0] BR_NON_ZERO = 2'b10;
  localparam logic [1:0] BR_ALWAYS   = 2'b11;

  logic        clk, rst_n, stall_in, flush_in, mem_read_in, mem_write_in;
  logic [1:0]  mem_width_in, branch_op_in;
  logic        mem_zero_extend_in, rd_writeback_in, data_ready_in;
  logic [4:0]  rd_in;
  logic [31:0] result_in, rs2_value_in, branch_pc_in, data_read_value_in;
  logic [31:0] data_address_out, data_write_value_out, branch_pc_out, rd_value_out;
  logic        data_read_out, data_write_out, busy_out, branch_taken_out, rd_writeback_out;
  logic [3:0]  data_write_mask_out;
  logic [4:0]  rd_out;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
  logic        trap_out;
`endif

  rv32_mem dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_width_in(mem_width_in),
    .mem_zero_extend_in(mem_zero_extend_in), .branch_op_in(branch_op_in),
    .rd_in(rd_in), .rd_writeback_in(rd_writeback_in), .result_in(result_in),
    .rs2_value_in(rs2_value_in), .branch_pc_in(branch_pc_in),
    .data_address_out(data_address_out), .data_read_out(data_read_out),
    .data_write_out(data_write_out), .data_write_mask_out(data_write_mask_out),
    .data_write_value_out(data_write_value_out), .data_read_value_in(data_read_value_in),
    .data_ready_in(data_ready_in), .busy_out(busy_out), .branch_taken_out(branch_taken_out),
    .branch_pc_out(branch_pc_out), .rd_out(rd_out), .rd_writeback_out(rd_writeback_out),
    .rd_value_out(rd_value_out)
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    , .trap_out(trap_out)
`endif
  );

  typedef struct {
    logic rd_en, wr_en; logic [1:0] width; logic zext; logic [1:0] bop; logic flush;
    logic [4:0] rd; logic wb; logic [31:0] result, rs2, bpc, rdata;
    logic [31:0] e_addr; logic e_read, e_write; logic [3:0] e_mask; logic [31:0] e_wdata;
    logic e_taken; logic [4:0] e_rd; logic e_wb; logic [31:0] e_value;
  } vec_t;

  typedef struct { logic [4:0] rd; logic wb; logic [31:0] value; logic trap; logic full; } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   busy_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  function automatic vec_t mk(
      input logic rd_en, input logic wr_en, input logic [1:0] width, input logic zext,
      input logic [1:0] bop, input logic flush, input logic [4:0] rd, input logic wb,
      input logic [31:0] result, input logic [31:0] rs2, input logic [31:0] bpc,
      input logic [31:0] rdata, input logic [31:0] e_addr, input logic e_read,
      input logic e_write, input logic [3:0] e_mask, input logic [31:0] e_wdata,
      input logic e_taken, input logic [4:0] e_rd, input logic e_wb, input logic [31:0] e_value);
    vec_t v;
    v.rd_en = rd_en; v.wr_en = wr_en; v.width = width; v.zext = zext; v.bop = bop;
    v.flush = flush; v.rd = rd; v.wb = wb; v.result = result; v.rs2 = rs2; v.bpc = bpc;
    v.rdata = rdata; v.e_addr = e_addr; v.e_read = e_read; v.e_write = e_write;
    v.e_mask = e_mask; v.e_wdata = e_wdata; v.e_taken = e_taken; v.e_rd = e_rd;
    v.e_wb = e_wb; v.e_value = e_value;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_bus(input string name, input logic [31:0] addr, input logic rd,
                         input logic wr, input logic [3:0] mask, input logic [31:0] wdata,
                         input logic busy);
    chk({name, "_addr"}, data_address_out, addr);
    chk({name, "_read"}, {31'd0, data_read_out}, {31'd0, rd});
    chk({name, "_write"}, {31'd0, data_write_out}, {31'd0, wr});
    chk({name, "_mask"}, {28'd0, data_write_mask_out}, {28'd0, mask});
    chk({name, "_wdata"}, data_write_value_out, wdata);
    chk({name, "_busy"}, {31'd0, busy_out}, {31'd0, busy});
  endtask

  task automatic push(input logic [4:0] rd, input logic wb, input logic [31:0] value,
                      input logic trap, input logic full);
    exp_t e;
    e.rd = rd; e.wb = wb; e.value = value; e.trap = trap; e.full = full;
    sb.push_back(e);
  endtask

  // Advance one clock, then compare the registered outputs with the oldest expectation.
  task automatic tick(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s_sb: got empty scoreboard, expected an entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_wb"}, {31'd0, rd_writeback_out}, {31'd0, e.wb});
      if (e.full) begin
        chk({name, "_rd"}, {27'd0, rd_out}, {27'd0, e.rd});
        chk({name, "_value"}, rd_value_out, e.value);
      end
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      chk({name, "_trap"}, {31'd0, trap_out}, {31'd0, e.trap});
`endif
    end
  endtask

  task automatic set_idle();
    stall_in = 1'b0; flush_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    mem_width_in = 2'b00; mem_zero_extend_in = 1'b0; branch_op_in = BR_NEVER;
    rd_in = 5'd0; rd_writeback_in = 1'b0; result_in = 32'd0; rs2_value_in = 32'd0;
    branch_pc_in = 32'd0; data_read_value_in = 32'd0; data_ready_in = 1'b0;
  endtask

  initial begin
    // Loads: rd_en wr_en width zext bop flush rd wb result rs2 bpc rdata | addr rd wr mask wdata taken rd wb value
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, BR_NEVER, 1'b0, 5'd5, 1'b1, 32'h0000_0103, 32'h0, 32'h0000_1000, 32'h80FF_FF7F,
                      32'h0000_0100, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd5, 1'b1, 32'hFFFF_FF80));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 1'b1, BR_NEVER, 1'b0, 5'd6, 1'b1, 32'h0000_0101, 32'h0, 32'h0000_1000, 32'h1234_9A78,
                      32'h0000_0100, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd6, 1'b1, 32'h0000_009A));
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b0, BR_NEVER, 1'b0, 5'd7, 1'b1, 32'h0000_0206, 32'h0, 32'h0000_1000, 32'h8001_7FFF,
                      32'h0000_0204, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd7, 1'b1, 32'hFFFF_8001));
    vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b1, BR_NEVER, 1'b0, 5'd8, 1'b1, 32'h0000_0204, 32'h0, 32'h0000_1000, 32'h8001_F00D,
                      32'h0000_0204, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd8, 1'b1, 32'h0000_F00D));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 1'b0, BR_NEVER, 1'b0, 5'd9, 1'b1, 32'h0000_0010, 32'h0, 32'h0000_1000, 32'hDEAD_BEEF,
                      32'h0000_0010, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd9, 1'b1, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b1, 1'b0, 2'b11, 1'b0, BR_NEVER, 1'b0, 5'd10, 1'b1, 32'h0000_0014, 32'h0, 32'h0000_1000, 32'hCAFE_BABE,
                      32'h0000_0014, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd10, 1'b1, 32'hCAFE_BABE));
    vecs.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, BR_NEVER, 1'b0, 5'd11, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_1000, 32'hAABB_CC7F,
                      32'h0000_0100, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd11, 1'b1, 32'h0000_007F));
    // Stores
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, BR_NEVER, 1'b0, 5'd0, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0000_1000, 32'h0,
                      32'h0000_0200, 1'b0, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 5'd0, 1'b0, 32'h0000_0202));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 1'b0, BR_NEVER, 1'b0, 5'd0, 1'b0, 32'h0000_0301, 32'h0000_00A5, 32'h0000_1000, 32'h0,
                      32'h0000_0300, 1'b0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0, 32'h0000_0301));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, BR_NEVER, 1'b0, 5'd0, 1'b0, 32'h0000_0040, 32'h0123_4567, 32'h0000_1000, 32'h0,
                      32'h0000_0040, 1'b0, 1'b1, 4'b1111, 32'h0123_4567, 1'b0, 5'd0, 1'b0, 32'h0000_0040));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, BR_NEVER, 1'b0, 5'd0, 1'b0, 32'h0000_0200, 32'hFFFF_1357, 32'h0000_1000, 32'h0,
                      32'h0000_0200, 1'b0, 1'b1, 4'b0011, 32'h1357_1357, 1'b0, 5'd0, 1'b0, 32'h0000_0200));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 1'b0, BR_NEVER, 1'b0, 5'd0, 1'b0, 32'h0000_0203, 32'h0000_0042, 32'h0000_1000, 32'h0,
                      32'h0000_0200, 1'b0, 1'b1, 4'b1000, 32'h4242_4242, 1'b0, 5'd0, 1'b0, 32'h0000_0203));
    // Non-memory ops and branches
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, BR_NEVER, 1'b0, 5'd12, 1'b1, 32'h0000_0055, 32'h0, 32'h0000_1000, 32'h0,
                      32'h0000_0054, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd12, 1'b1, 32'h0000_0055));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, BR_ZERO, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 32'h0, 32'h8000_0100, 32'h0,
                      32'h0000_0000, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, BR_ZERO, 1'b1, 5'd4, 1'b1, 32'h0000_0000, 32'h0, 32'h8000_0100, 32'h0,
                      32'h0000_0000, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, BR_NON_ZERO, 1'b0, 5'd0, 1'b0, 32'h0000_0005, 32'h0, 32'h8000_0200, 32'h0,
                      32'h0000_0004, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0000_0005));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, BR_NON_ZERO, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 32'h0, 32'h8000_0300, 32'h0,
                      32'h0000_0000, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, BR_ZERO, 1'b0, 5'd0, 1'b0, 32'h0000_0004, 32'h0, 32'h8000_0400, 32'h0,
                      32'h0000_0004, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0000_0004));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, BR_ALWAYS, 1'b0, 5'd0, 1'b0, 32'h0000_0008, 32'h0, 32'h8000_0500, 32'h0,
                      32'h0000_0008, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0000_0008));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, BR_NEVER, 1'b0, 5'd0, 1'b0, 32'h0000_0000, 32'h0, 32'h8000_0600, 32'h0,
                      32'h0000_0000, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0000_0000));
    // Flushed memory requests: no bus activity, bubble
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 1'b0, BR_NEVER, 1'b1, 5'd13, 1'b1, 32'h0000_0104, 32'h0, 32'h0000_1000, 32'h1111_1111,
                      32'h0000_0104, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, BR_NEVER, 1'b1, 5'd0, 1'b0, 32'h0000_0108, 32'h5555_AAAA, 32'h0000_1000, 32'h0,
                      32'h0000_0108, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0000_0000));

    // Reset: bus quiet even with a request on the inputs, registers cleared.
    set_idle();
    rst_n = 1'b0;
    mem_read_in = 1'b1; mem_write_in = 1'b1; mem_width_in = 2'b10; result_in = 32'h0000_0123;
    rs2_value_in = 32'hFFFF_FFFF; data_ready_in = 1'b0;
    #3;
    chk_bus("rst", 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    chk("rst_wb", {31'd0, rd_writeback_out}, 32'd0);
    chk("rst_value", rd_value_out, 32'd0);
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    chk("rst_trap", {31'd0, trap_out}, 32'd0);
`endif
    rst_n = 1'b1;
    set_idle();

    // Table: single-cycle operations with the bus ready in the same cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      stall_in = 1'b0; data_ready_in = 1'b1;
      mem_read_in = vecs[i].rd_en; mem_write_in = vecs[i].wr_en; mem_width_in = vecs[i].width;
      mem_zero_extend_in = vecs[i].zext; branch_op_in = vecs[i].bop; flush_in = vecs[i].flush;
      rd_in = vecs[i].rd; rd_writeback_in = vecs[i].wb; result_in = vecs[i].result;
      rs2_value_in = vecs[i].rs2; branch_pc_in = vecs[i].bpc; data_read_value_in = vecs[i].rdata;
      #4;
      chk_bus($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_read, vecs[i].e_write,
              vecs[i].e_mask, vecs[i].e_wdata, 1'b0);
      chk($sformatf("v%0d_taken", i), {31'd0, branch_taken_out}, {31'd0, vecs[i].e_taken});
      chk($sformatf("v%0d_bpc", i), branch_pc_out, vecs[i].bpc);
      push(vecs[i].e_rd, vecs[i].e_wb, vecs[i].e_value, 1'b0, 1'b1);
      tick($sformatf("v%0d", i));
    end
    set_idle();

    // Word load with ready after three cycles: stable latched request, three bubbles.
    mem_read_in = 1'b1; mem_width_in = 2'b10; result_in = 32'h0000_0500;
    rd_in = 5'd14; rd_writeback_in = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        mem_read_in = 1'b0; result_in = 32'h9999_0000; rd_in = 5'd1;
      end
      data_ready_in = (c == 3);
      data_read_value_in = (c == 3) ? 32'h1357_2468 : 32'hFFFF_FFFF;
      #4;
      chk($sformatf("wait%0d_addr", c), data_address_out, 32'h0000_0500);
      chk($sformatf("wait%0d_read", c), {31'd0, data_read_out}, 32'd1);
      chk($sformatf("wait%0d_busy", c), {31'd0, busy_out}, {31'd0, (c < 3)});
      if (busy_out) busy_cnt++;
      if (c < 3) push(5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      else       push(5'd14, 1'b1, 32'h1357_2468, 1'b0, 1'b1);
      tick($sformatf("wait%0d", c));
    end
    chk("wait_busy_cycles", busy_cnt, 32'd3);
    set_idle();

    // Flush during WAIT: the transfer still completes, writeback suppressed.
    mem_read_in = 1'b1; mem_width_in = 2'b10; result_in = 32'h0000_0600;
    rd_in = 5'd15; rd_writeback_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        mem_read_in = 1'b0; rd_writeback_in = 1'b0;
      end
      flush_in = (c == 1);
      data_ready_in = (c == 3);
      data_read_value_in = 32'h2468_ACE0;
      #4;
      chk($sformatf("fl%0d_read", c), {31'd0, data_read_out}, 32'd1);
      chk($sformatf("fl%0d_addr", c), data_address_out, 32'h0000_0600);
      chk($sformatf("fl%0d_busy", c), {31'd0, busy_out}, {31'd0, (c < 3)});
      push(5'd0, 1'b0, 32'd0, 1'b0, (c < 3));
      tick($sformatf("fl%0d", c));
    end
    set_idle();

    // Stall without busy: the request is issued once, registers hold, result lands after stall.
    rd_in = 5'd3; rd_writeback_in = 1'b1; result_in = 32'h0000_0077;
    #4;
    push(5'd3, 1'b1, 32'h0000_0077, 1'b0, 1'b1);
    tick("st_pre");
    mem_read_in = 1'b1; mem_width_in = 2'b00; mem_zero_extend_in = 1'b1;
    result_in = 32'h0000_0702; rd_in = 5'd16; rd_writeback_in = 1'b1;
    data_ready_in = 1'b1; data_read_value_in = 32'h00AB_0000; stall_in = 1'b1;
    #4;
    chk("st0_read", {31'd0, data_read_out}, 32'd1);
    chk("st0_busy", {31'd0, busy_out}, 32'd0);
    push(5'd3, 1'b1, 32'h0000_0077, 1'b0, 1'b1);
    tick("st0");
    data_read_value_in = 32'h0011_0000;
    #4;
    chk("st1_read", {31'd0, data_read_out}, 32'd0);
    chk("st1_busy", {31'd0, busy_out}, 32'd0);
    push(5'd3, 1'b1, 32'h0000_0077, 1'b0, 1'b1);
    tick("st1");
    stall_in = 1'b0;
    #4;
    chk("st2_read", {31'd0, data_read_out}, 32'd0);
    push(5'd16, 1'b1, 32'h0000_00AB, 1'b0, 1'b1);
    tick("st2");
    set_idle();
    #4;
    push(5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick("st3");

    // Reset while waiting abandons the transfer; the block comes back in IDLE.
    mem_read_in = 1'b1; mem_width_in = 2'b10; result_in = 32'h0000_0800;
    rd_in = 5'd17; rd_writeback_in = 1'b1; data_ready_in = 1'b0;
    #4;
    chk("rw_busy", {31'd0, busy_out}, 32'd1);
    push(5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick("rw0");
    set_idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_bus("rw_rst", 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0);
    chk("rw_rst_wb", {31'd0, rd_writeback_out}, 32'd0);
    chk("rw_rst_rd", {27'd0, rd_out}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_read_in = 1'b1; mem_width_in = 2'b10; result_in = 32'h0000_0900;
    rd_in = 5'd18; rd_writeback_in = 1'b1; data_ready_in = 1'b1;
    data_read_value_in = 32'h0BAD_F00D;
    #4;
    chk_bus("rw_post", 32'h0000_0900, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b0);
    push(5'd18, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b1);
    tick("rw_post");
    set_idle();

`ifdef RV32_MEM_MISALIGN_TRAP_EN
    // Misaligned word load: no bus request, one-cycle trap pulse.
    mem_read_in = 1'b1; mem_width_in = 2'b10; result_in = 32'h0000_0301;
    rd_in = 5'd19; rd_writeback_in = 1'b1; data_ready_in = 1'b1;
    #4;
    chk("mis_read", {31'd0, data_read_out}, 32'd0);
    chk("mis_busy", {31'd0, busy_out}, 32'd0);
    push(5'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    tick("mis0");
    set_idle();
    #4;
    push(5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick("mis1");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv32_mem.md
RV32_MEM -- requirements
Module: rv32_mem

Interface
REQ-001 Parameters: none; all widths fixed (RV32).
REQ-002 clk  in  1  pipeline clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 stall_in, flush_in  in  1 each  hazard control: hold outputs / squash current instruction.
REQ-005 mem_read_in, mem_write_in  in  1 each  load / store request from execute.
REQ-006 mem_width_in  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 mem_zero_extend_in  in  1  load zero-extends when 1, sign-extends when 0.
REQ-008 branch_op_in  in  2  RV32_BRANCH_OP_NEVER/ZERO/NON_ZERO/ALWAYS.
REQ-009 rd_in  in  5; rd_writeback_in  in  1  destination register and write enable.
REQ-010 result_in, rs2_value_in, branch_pc_in  in  32 each  ALU result/address, store data, branch target.
REQ-011 data_address_out  out  32; data_read_out, data_write_out  out  1; data_write_mask_out  out  4; data_write_value_out  out  32  data bus request.
REQ-012 data_read_value_in  in  32; data_ready_in  in  1  bus response; transfer completes in a cycle with request and ready both high.
REQ-013 busy_out  out  1  stall request to hazard unit.
REQ-014 branch_taken_out  out  1; branch_pc_out  out  32  fetch redirect.
REQ-015 rd_out  out  5; rd_writeback_out  out  1; rd_value_out  out  32  registered, to writeback.
REQ-016 trap_out  out  1  misaligned-access trap, present only with RV32_MEM_MISALIGN_TRAP_EN.

Function
REQ-017 States IDLE and WAIT; IDLE: bus driven combinationally from inputs; WAIT: bus driven from internally latched request.
REQ-018 IDLE, access present, !flush_in: if data_ready_in same cycle, complete with zero added latency; else enter WAIT latching address, width, extend, mask, write data, rd, rd_writeback.
REQ-019 WAIT: hold request stable, busy_out=1; on data_ready_in return to IDLE and complete; busy_out=0 in that cycle.
REQ-020 busy_out = (IDLE and access and !ready) or (WAIT and !ready).
REQ-021 data_address_out = {addr[31:2],2'b00}.
REQ-022 Store mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<(2*addr[1]); word 4'b1111; data: byte replicated x4, half replicated x2, word as-is.
REQ-023 Load: select byte lane addr[1:0] or half lane addr[1]; extend per mem_zero_extend_in; word passes through.
REQ-024 branch_taken_out = !flush_in and (ALWAYS, or ZERO with result_in==0, or NON_ZERO with result_in!=0); branch_pc_out = branch_pc_in; combinational.
REQ-025 Output registers update only when !stall_in: completing op loads rd, rd_writeback, load data or result_in; busy cycles load a bubble (rd_writeback_out=0).
REQ-026 flush_in in IDLE: no bus request, bubble loaded.
REQ-027 flush_in during WAIT: transaction continues to completion (never aborted); result discarded, rd_writeback_out=0.
REQ-028 stall_in high with no busy: registers hold; bus request still issued once only (no repeat after completion while stalled).

Reset
REQ-029 rst_n low: state IDLE, rd_out=0, rd_writeback_out=0, rd_value_out=0, trap_out=0, latched request cleared; bus outputs 0 while rst_n low.
REQ-030 Reset mid-WAIT abandons the transaction immediately; no writeback results.

Configuration
REQ-031 RV32_MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no bus request, registers trap_out=1 for one cycle, rd_writeback_out=0.
REQ-032 RV32_MEM_MISALIGN_TRAP_EN undefined: no trap_out port; low address bits ignored beyond lane selection (half uses addr[1], word forced aligned).

Verification
REQ-033 Load byte, addr 0x103, data 0x80FF_FF7F, ready same cycle, sign-extend -> next cycle rd_value_out=0xFFFF_FF80, busy_out never high.
REQ-034 Store half, addr 0x202, rs2=0x1234_ABCD -> address 0x200, mask 4'b1100, data 0xABCD_ABCD.
REQ-035 Load word, ready after 3 cycles -> busy_out high 3 cycles, 3 bubbles out, address stable, then rd_value_out=bus data.
REQ-036 Flush asserted in WAIT, ready 2 cycles later -> bus completes, rd_writeback_out stays 0.
REQ-037 branch_op ZERO, result_in=0 -> branch_taken_out=1, branch_pc_out=branch_pc_in; with flush_in=1 -> 0.
REQ-038 Macro on, word load addr 0x301 -> no data_read_out, trap_out one-cycle pulse; rst_n low in WAIT -> IDLE, busy_out=0.
